// File: rtl/grf_pkg.sv
// Shared types and constants for the general register file and its clients.
// The GRF_BYPASS_EN macro is consumed by grf_read_port, not by this package.
package grf_pkg;

  localparam int GRF_DATA_W = 32;
  localparam int GRF_ADDR_W = 5;

  typedef logic [GRF_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = reg_idx_t'(0);
  localparam reg_idx_t REG_RA   = reg_idx_t'(31);

endpackage

// File: rtl/grf_if.sv
// Register-file access bundle: two read ports toward the ALU and one write-back port.
// The controller side uses the master modport; the register file uses slave.
interface grf_if
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W
);

  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  modport master (
    output ra1, ra2, we, wa, wd,
    input  rd1, rd2
  );

  modport slave (
    input  ra1, ra2, we, wa, wd,
    output rd1, rd2
  );

endinterface

// File: rtl/grf_read_port.sv
// One combinational read port: zero-index check, storage mux and optional
// same-cycle write forwarding (enabled by defining GRF_BYPASS_EN).
module grf_read_port
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W
) (
  input  logic                                 i_rst_n,
  input  logic [ADDR_W-1:0]                    i_ra,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]     i_regs,
  input  logic                                 i_we,
  input  logic [ADDR_W-1:0]                    i_wa,
  input  logic [DATA_W-1:0]                    i_wd,
  output logic [DATA_W-1:0]                    o_rd
);

  logic [DATA_W-1:0] w_stored;

  always_comb begin
    w_stored = '0;
    if (i_ra != '0) begin
      w_stored = i_regs[i_ra];
    end
  end

`ifdef GRF_BYPASS_EN
  // Forward only a real write; index 0 and an active reset never forward.
  logic w_fwd;
  assign w_fwd = i_rst_n && i_we && (i_wa != '0) && (i_wa == i_ra);
  assign o_rd  = w_fwd ? i_wd : w_stored;
`else
  logic w_unused;
  assign w_unused = &{1'b0, i_rst_n, i_we, i_wa, i_wd};
  assign o_rd     = w_stored;
`endif

endmodule

// File: rtl/grf.sv
// 32 x 32-bit general register file with register 0 hard-wired to zero.
// Define GRF_BYPASS_EN to forward write-back data to the read ports in the same cycle.
module grf
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W
) (
  input  logic   clk,
  input  logic   rst_n,
  grf_if.slave   bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] r_regs;
  logic [DATA_W-1:0]            w_rd1;
  logic [DATA_W-1:0]            w_rd2;

  // Entry 0 is cleared by reset and never targeted by a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else if (bus.we && (bus.wa != '0)) begin
      r_regs[bus.wa] <= bus.wd;
    end
  end

  grf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rp1 (
    .i_rst_n (rst_n),
    .i_ra    (bus.ra1),
    .i_regs  (r_regs),
    .i_we    (bus.we),
    .i_wa    (bus.wa),
    .i_wd    (bus.wd),
    .o_rd    (w_rd1)
  );

  grf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rp2 (
    .i_rst_n (rst_n),
    .i_ra    (bus.ra2),
    .i_regs  (r_regs),
    .i_we    (bus.we),
    .i_wa    (bus.wa),
    .i_wd    (bus.wd),
    .o_rd    (w_rd2)
  );

  assign bus.rd1 = w_rd1;
  assign bus.rd2 = w_rd2;

endmodule
